mips_sim_loader: RTL and testbench
==================================

# mips_sim_loader

Synthesizable program loader and run supervisor for the pipelined MIPS core. It holds the core in reset while a word stream fills instruction and data memory, then releases the core and counts run cycles. Each run ends on a core halt signal or on a cycle budget. It replaces fixed-path memory preloading and fixed-delay finish, so the same bench or an FPGA host link can load any program into any memory size.

## Interface
Parameters:
- IM_DEPTH, 256, instruction memory depth in 32-bit words
- DM_DEPTH, 256, data memory depth in 32-bit words
- MAX_CYCLES, 500, run-cycle budget before timeout (≥1)
- CNT_W, 32, width of cycle counter

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  stream word valid
- in_ready  out  1  loader accepts word this cycle
- in_data  in  32  header or payload word
- cpu_halt  in  1  core reports halt (level, sampled in RUN only)
- cpu_rst  out  1  reset to core and PC (active-high)
- im_we / dm_we  out  1  memory write strobes
- im_addr  out  clog2(IM_DEPTH)  IM word address
- dm_addr  out  clog2(DM_DEPTH)  DM word address
- im_wdata / dm_wdata  out  32  write data
- cycle_count  out  CNT_W  cycles run with cpu_rst low
- done  out  1  run ended by cpu_halt
- timeout  out  1  run ended by budget
- err  out  1  sticky: bad region code or out-of-range address

## Operation
- States: HDR, LOAD, RUN, DONE, TIMEOUT. Reset enters HDR.
- A transfer is in_valid & in_ready. in_ready = 1 only in HDR and LOAD.
- Header fields: [31:30] region, [29:16] base word address, [15:0] count.
- Region codes: 0 = IM, 1 = DM, 2 = invalid, 3 = GO.
- Region 2 sets err and stays in HDR; its count is ignored.
- HDR, region 0/1, count > 0: latch region, base, count; go to LOAD.
- HDR, region 0/1, count = 0: stay in HDR; no writes.
- HDR, region 3: go to RUN. Base and count are ignored.
- LOAD: each accepted word writes the latched region at the current address. The address then increments and the remaining count decrements. After the last word, return to HDR.
- Out-of-range address (addr ≥ DEPTH of the region): suppress the write and set err. The word is still consumed; the address does not wrap.
- RUN: cpu_rst = 0. cycle_count increments every RUN cycle.
- In RUN, cpu_halt high moves to DONE; this takes priority over timeout in the same cycle.
- In RUN, cycle_count = MAX_CYCLES−1 with no halt moves to TIMEOUT.
- DONE and TIMEOUT: cpu_rst = 1, which freezes the core. cycle_count holds. The state stays until rst.
- Only one of im_we and dm_we is ever high in a cycle.

## Timing
- Reset values: state HDR, cpu_rst=1, in_ready=1, all write strobes and addresses 0, wdata 0, cycle_count 0, done/timeout/err 0.
- All outputs are registered except in_ready, which is decoded from state.
- Write latency: a word accepted in cycle n produces its strobe, address and data in cycle n+1 for one cycle.
- Back-to-back accepts produce back-to-back writes at consecutive addresses.
- GO accepted in cycle n: cpu_rst falls in n+1. cycle_count reads 1 at the end of the first RUN cycle.
- Timeout: exactly MAX_CYCLES RUN cycles. timeout and cpu_rst rise together, and cycle_count = MAX_CYCLES.
- Halt sampled in cycle m: done and cpu_rst rise in m+1.
- rst at any time, including mid-LOAD or RUN, restarts in HDR next cycle. Any partially loaded memory contents are left as they are.

## Structure
- Shared package mips_sim_pkg: state enum, region codes (REG_IM, REG_DM, REG_BAD, REG_GO), header field positions/widths.
- One natural sub-module: sat_cycle_counter (enable, clear, saturating count, terminal flag at a parameter limit). It is reusable for pipeline stall profiling.
- Address and remaining-count registers live in the top module.

## Test plan
- IM header base 0 count 3, words A0,A1,A2 back-to-back → im_we on 3 consecutive cycles, addresses 0,1,2 with data A0..A2; state returns to HDR.
- DM header base 4 count 2 with a 2-cycle in_valid gap between words → dm_we pulses at addr 4 then 5, one cycle after each accept; im_we stays 0.
- IM_DEPTH=8, header base 7 count 2 → write at addr 7; the second word is consumed with no strobe; err=1.
- GO, then cpu_halt raised after 20 RUN cycles → done=1, timeout=0, cycle_count=20, cpu_rst=1.
- MAX_CYCLES=50, GO, halt never asserted → timeout=1 with cycle_count=50; cpu_halt later ignored.
- rst asserted mid-LOAD (after 1 of 3 words) → next cycle: state HDR, cpu_rst=1, strobes 0, err 0; a fresh header is accepted.

Source files
------------

// File: rtl/mips_sim_pkg.sv
// Shared types for the MIPS simulation loader.
// Defines the supervisor state enum, stream region codes and the header word
// layout: [31:30] region, [29:16] base word address, [15:0] word count.
package mips_sim_pkg;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_LOAD,
    ST_RUN,
    ST_DONE,
    ST_TIMEOUT
  } state_e;

  typedef enum logic [1:0] {
    REG_IM  = 2'd0,
    REG_DM  = 2'd1,
    REG_BAD = 2'd2,
    REG_GO  = 2'd3
  } region_e;

  localparam int REG_W  = 2;
  localparam int BASE_W = 14;
  localparam int LEN_W  = 16;

  // The load address never wraps, so it must hold base + count without overflow.
  localparam int LADDR_W = 17;

  typedef struct packed {
    region_e             region;  // [31:30]
    logic [BASE_W-1:0]   base;    // [29:16]
    logic [LEN_W-1:0]    count;   // [15:0]
  } hdr_t;

endpackage

// File: rtl/sat_cycle_counter.sv
// Saturating cycle counter with a terminal flag.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   en_i      - count this cycle
//   clr_i     - synchronous clear (wins over en_i)
//   count_o   - registered count, sticks at all-ones
//   term_o    - count_o has reached LIMIT-1, i.e. the next enabled
//               cycle is the LIMIT-th one
module sat_cycle_counter #(
  parameter int W     = 32,
  parameter int LIMIT = 500
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o,
  output logic         term_o
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)
      count_d = '0;
    else if (en_i && (count_q != '1))
      count_d = count_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;
  assign term_o  = (count_q >= LAST);

endmodule

// File: rtl/mips_sim_loader.sv
// Program loader and run supervisor for the pipelined MIPS core.
// Holds the core in reset while a header/payload word stream fills IM and DM,
// then releases it on a GO header and counts run cycles until halt or budget.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   in_valid/in_ready     - word stream handshake; in_data is header or payload
//   cpu_halt              - core halt level, only looked at while running
//   cpu_rst               - core/PC reset, low only while running
//   im_*/dm_*             - registered single-cycle memory write ports
//   cycle_count           - number of cycles run with cpu_rst low
//   done/timeout          - run ended by halt / by cycle budget
//   err                   - sticky: bad region code or out-of-range write
module mips_sim_loader
  import mips_sim_pkg::*;
#(
  parameter int IM_DEPTH   = 256,
  parameter int DM_DEPTH   = 256,
  parameter int MAX_CYCLES = 500,
  parameter int CNT_W      = 32,
  localparam int IM_AW     = (IM_DEPTH > 1) ? $clog2(IM_DEPTH) : 1,
  localparam int DM_AW     = (DM_DEPTH > 1) ? $clog2(DM_DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             cpu_halt,
  output logic             cpu_rst,
  output logic             im_we,
  output logic             dm_we,
  output logic [IM_AW-1:0] im_addr,
  output logic [DM_AW-1:0] dm_addr,
  output logic [31:0]      im_wdata,
  output logic [31:0]      dm_wdata,
  output logic [CNT_W-1:0] cycle_count,
  output logic             done,
  output logic             timeout,
  output logic             err
);

  state_e               state_q, state_d;
  region_e              reg_q, reg_d;
  logic [LADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]     rem_q, rem_d;

  logic                 im_we_q, im_we_d, dm_we_q, dm_we_d;
  logic [IM_AW-1:0]     im_addr_q, im_addr_d;
  logic [DM_AW-1:0]     dm_addr_q, dm_addr_d;
  logic [31:0]          im_wdata_q, im_wdata_d, dm_wdata_q, dm_wdata_d;
  logic                 cpu_rst_q, cpu_rst_d;
  logic                 done_q, done_d, timeout_q, timeout_d, err_q, err_d;

  logic                 xfer, run, term;
  logic                 im_in_range, dm_in_range;
  hdr_t                 hdr;

  assign in_ready    = (state_q == ST_HDR) || (state_q == ST_LOAD);
  assign xfer        = in_valid && in_ready;
  assign run         = (state_q == ST_RUN);
  assign hdr         = hdr_t'(in_data);
  assign im_in_range = (32'(addr_q) < 32'(IM_DEPTH));
  assign dm_in_range = (32'(addr_q) < 32'(DM_DEPTH));

  sat_cycle_counter #(
    .W     (CNT_W),
    .LIMIT (MAX_CYCLES)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .en_i    (run),
    .clr_i   (1'b0),
    .count_o (cycle_count),
    .term_o  (term)
  );

  always_comb begin
    state_d    = state_q;
    reg_d      = reg_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    im_we_d    = 1'b0;
    dm_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    dm_addr_d  = dm_addr_q;
    im_wdata_d = im_wdata_q;
    dm_wdata_d = dm_wdata_q;
    cpu_rst_d  = cpu_rst_q;
    done_d     = done_q;
    timeout_d  = timeout_q;
    err_d      = err_q;

    case (state_q)
      ST_HDR: begin
        if (xfer) begin
          case (hdr.region)
            REG_IM, REG_DM: begin
              // A zero-length region is a no-op header.
              if (hdr.count != '0) begin
                reg_d   = hdr.region;
                addr_d  = LADDR_W'(hdr.base);
                rem_d   = hdr.count;
                state_d = ST_LOAD;
              end
            end
            REG_BAD: err_d = 1'b1;
            default: begin
              state_d   = ST_RUN;
              cpu_rst_d = 1'b0;
            end
          endcase
        end
      end

      ST_LOAD: begin
        if (xfer) begin
          // Out-of-range words are swallowed without a strobe.
          if (reg_q == REG_IM) begin
            if (im_in_range) begin
              im_we_d    = 1'b1;
              im_addr_d  = addr_q[IM_AW-1:0];
              im_wdata_d = in_data;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            if (dm_in_range) begin
              dm_we_d    = 1'b1;
              dm_addr_d  = addr_q[DM_AW-1:0];
              dm_wdata_d = in_data;
            end else begin
              err_d = 1'b1;
            end
          end
          addr_d = addr_q + LADDR_W'(1);
          rem_d  = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = ST_HDR;
        end
      end

      ST_RUN: begin
        // Halt wins over budget expiry in the same cycle.
        if (cpu_halt) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          cpu_rst_d = 1'b1;
        end else if (term) begin
          state_d   = ST_TIMEOUT;
          timeout_d = 1'b1;
          cpu_rst_d = 1'b1;
        end
      end

      default: ; // DONE / TIMEOUT park until rst
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_HDR;
      reg_q      <= REG_IM;
      addr_q     <= '0;
      rem_q      <= '0;
      im_we_q    <= 1'b0;
      dm_we_q    <= 1'b0;
      im_addr_q  <= '0;
      dm_addr_q  <= '0;
      im_wdata_q <= '0;
      dm_wdata_q <= '0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      reg_q      <= reg_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      im_we_q    <= im_we_d;
      dm_we_q    <= dm_we_d;
      im_addr_q  <= im_addr_d;
      dm_addr_q  <= dm_addr_d;
      im_wdata_q <= im_wdata_d;
      dm_wdata_q <= dm_wdata_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      err_q      <= err_d;
    end
  end

  assign im_we    = im_we_q;
  assign dm_we    = dm_we_q;
  assign im_addr  = im_addr_q;
  assign dm_addr  = dm_addr_q;
  assign im_wdata = im_wdata_q;
  assign dm_wdata = dm_wdata_q;
  assign cpu_rst  = cpu_rst_q;
  assign done     = done_q;
  assign timeout  = timeout_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mips_sim_loader.sv
module tb_mips_sim_loader;

  localparam int IM_DEPTH   = 8;
  localparam int DM_DEPTH   = 16;
  localparam int MAX_CYCLES = 50;
  localparam int CNT_W      = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        cpu_halt = 1'b0;
  logic        cpu_rst;
  logic        im_we, dm_we;
  logic [2:0]  im_addr;
  logic [3:0]  dm_addr;
  logic [31:0] im_wdata, dm_wdata;
  logic [CNT_W-1:0] cycle_count;
  logic        done, timeout, err;

  int checks = 0;
  int errors = 0;

  mips_sim_loader #(
    .IM_DEPTH   (IM_DEPTH),
    .DM_DEPTH   (DM_DEPTH),
    .MAX_CYCLES (MAX_CYCLES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .cpu_halt    (cpu_halt),
    .cpu_rst     (cpu_rst),
    .im_we       (im_we),
    .dm_we       (dm_we),
    .im_addr     (im_addr),
    .dm_addr     (dm_addr),
    .im_wdata    (im_wdata),
    .dm_wdata    (dm_wdata),
    .cycle_count (cycle_count),
    .done        (done),
    .timeout     (timeout),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] hdr(input logic [1:0] r, input int b, input int c);
    return {r, b[13:0], c[15:0]};
  endfunction

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word for one cycle; outputs for that word are visible on return.
  task automatic send(input logic [31:0] w);
    in_valid = 1'b1;
    in_data  = w;
    tick();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    cpu_halt = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    do_reset();

    // Reset state
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_cpu_rst",  32'(cpu_rst), 1);
    chk("rst_im_we",    32'(im_we), 0);
    chk("rst_dm_we",    32'(dm_we), 0);
    chk("rst_im_addr",  32'(im_addr), 0);
    chk("rst_dm_addr",  32'(dm_addr), 0);
    chk("rst_im_wdata", im_wdata, 0);
    chk("rst_dm_wdata", dm_wdata, 0);
    chk("rst_count",    cycle_count, 0);
    chk("rst_done",     32'(done), 0);
    chk("rst_timeout",  32'(timeout), 0);
    chk("rst_err",      32'(err), 0);

    // Zero-count header must leave the loader in HDR, so the next word is a header.
    send(hdr(2'd0, 5, 0));
    chk("z_im_we", 32'(im_we), 0);

    // IM base 0 count 3, back-to-back
    send(hdr(2'd0, 0, 3));
    chk("t1_hdr_no_we", 32'(im_we), 0);
    send(32'hA000_0000);
    chk("t1_we0", 32'(im_we), 1); chk("t1_a0", 32'(im_addr), 0); chk("t1_d0", im_wdata, 32'hA000_0000);
    send(32'hA111_1111);
    chk("t1_we1", 32'(im_we), 1); chk("t1_a1", 32'(im_addr), 1); chk("t1_d1", im_wdata, 32'hA111_1111);
    send(32'hA222_2222);
    chk("t1_we2", 32'(im_we), 1); chk("t1_a2", 32'(im_addr), 2); chk("t1_d2", im_wdata, 32'hA222_2222);
    chk("t1_dm_we", 32'(dm_we), 0);
    in_valid = 1'b0;
    tick();
    chk("t1_we_off", 32'(im_we), 0);
    chk("t1_hdr", 32'(in_ready), 1);

    // DM base 4 count 2 with 2-cycle gap
    send(hdr(2'd1, 4, 2));
    in_valid = 1'b0;
    tick();
    tick();
    chk("t2_gap_we", 32'(dm_we), 0);
    send(32'hD000_0004);
    chk("t2_we0", 32'(dm_we), 1); chk("t2_a0", 32'(dm_addr), 4); chk("t2_d0", dm_wdata, 32'hD000_0004);
    chk("t2_im_we0", 32'(im_we), 0);
    in_valid = 1'b0;
    tick();
    chk("t2_pulse", 32'(dm_we), 0);
    tick();
    send(32'hD000_0005);
    chk("t2_we1", 32'(dm_we), 1); chk("t2_a1", 32'(dm_addr), 5); chk("t2_d1", dm_wdata, 32'hD000_0005);
    chk("t2_im_we1", 32'(im_we), 0);
    in_valid = 1'b0;
    tick();
    chk("t2_hdr", 32'(in_ready), 1);

    // IM base 7 count 2 with IM_DEPTH 8: second word is out of range
    send(hdr(2'd0, 7, 2));
    send(32'hB777_7777);
    chk("t3_we", 32'(im_we), 1); chk("t3_a", 32'(im_addr), 7); chk("t3_err0", 32'(err), 0);
    send(32'hB888_8888);
    chk("t3_no_we", 32'(im_we), 0); chk("t3_err1", 32'(err), 1);
    in_valid = 1'b0;
    tick();
    chk("t3_hdr", 32'(in_ready), 1);

    // Halt after 20 run cycles
    do_reset();
    chk("t4_err_clr", 32'(err), 0);
    send(hdr(2'd3, 0, 0));
    in_valid = 1'b0;
    chk("t4_cpu_rst0", 32'(cpu_rst), 0);
    chk("t4_not_ready", 32'(in_ready), 0);
    repeat (19) tick();
    chk("t4_cnt19", cycle_count, 19);
    cpu_halt = 1'b1;
    tick();
    chk("t4_done", 32'(done), 1);
    chk("t4_timeout", 32'(timeout), 0);
    chk("t4_cnt", cycle_count, 20);
    chk("t4_cpu_rst", 32'(cpu_rst), 1);
    cpu_halt = 1'b0;
    repeat (5) tick();
    chk("t4_cnt_hold", cycle_count, 20);
    chk("t4_done_hold", 32'(done), 1);

    // Budget timeout, halt afterwards ignored
    do_reset();
    send(hdr(2'd3, 0, 0));
    in_valid = 1'b0;
    n = 0;
    while (!timeout && n < 200) begin
      tick();
      n++;
    end
    chk("t5_cycles", 32'(n), MAX_CYCLES);
    chk("t5_timeout", 32'(timeout), 1);
    chk("t5_cnt", cycle_count, MAX_CYCLES);
    chk("t5_cpu_rst", 32'(cpu_rst), 1);
    chk("t5_done0", 32'(done), 0);
    cpu_halt = 1'b1;
    repeat (3) tick();
    chk("t5_done_ign", 32'(done), 0);
    chk("t5_cnt_hold", cycle_count, MAX_CYCLES);
    cpu_halt = 1'b0;

    // Reset mid-load, then fresh header; bad region sets err
    do_reset();
    send(hdr(2'd0, 0, 3));
    send(32'hC000_0000);
    chk("t6_we", 32'(im_we), 1);
    send(hdr(2'd2, 0, 9));
    chk("t6_err_none_yet", 32'(err), 0);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_ready", 32'(in_ready), 1);
    chk("t6_cpu_rst", 32'(cpu_rst), 1);
    chk("t6_im_we", 32'(im_we), 0);
    chk("t6_dm_we", 32'(dm_we), 0);
    chk("t6_err", 32'(err), 0);
    send(hdr(2'd2, 3, 9));
    chk("t6_bad_err", 32'(err), 1);
    chk("t6_bad_ready", 32'(in_ready), 1);
    send(hdr(2'd1, 2, 1));
    send(32'hCCCC_0002);
    chk("t6_dm_we1", 32'(dm_we), 1);
    chk("t6_dm_a", 32'(dm_addr), 2);
    chk("t6_dm_d", dm_wdata, 32'hCCCC_0002);
    chk("t6_im_we1", 32'(im_we), 0);
    in_valid = 1'b0;
    tick();
    chk("t6_hdr", 32'(in_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
